// File: rtl/reg_timeout_guard_pkg.sv
// Shared types and constants for the register-bus timeout guard.
// Holds the bus structs, FSM state codes and counter width.
package reg_timeout_guard_pkg;

    localparam int unsigned CNT_W = 16;
    localparam logic [31:0] ERR_RDATA_DEF = 32'hBADCAB1E;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WAIT  = 2'd1;
    localparam state_t ST_ERR   = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

// File: rtl/reg_timeout_sat_cnt.sv
// Saturating event counter with synchronous clear.
// Clear together with an increment leaves the count at one.
module reg_timeout_sat_cnt
    import reg_timeout_guard_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // next count: clear wins over hold, increment stops at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = inc_i ? WIDTH'(1) : '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_timeout_guard.sv
// Register-bus guard: forwards transactions, answers with an error
// when the peripheral does not become ready within TIMEOUT cycles.
module reg_timeout_guard
    import reg_timeout_guard_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF,
    parameter type         req_t     = reg_req_t,
    parameter type         rsp_t     = reg_rsp_t
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  req_t             in_req_i,
    output rsp_t             in_rsp_o,
    output req_t             out_req_o,
    input  rsp_t             out_rsp_i,
    input  logic             clear_cnt_i,
    output logic             timeout_o,
    output logic [CNT_W-1:0] timeout_cnt_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] drain_q, drain_d;
    logic             err_cyc;

    assign err_cyc = (state_q == ST_ERR);

    // next-state and cycle counters of the guard FSM
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        drain_d = drain_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_req_i.valid && !out_rsp_i.ready) begin
                    state_d = ST_WAIT;
                    wait_d  = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!in_req_i.valid || out_rsp_i.ready) begin
                    state_d = ST_IDLE;
                    wait_d  = '0;
                end else if (wait_q == LAST) begin
                    state_d = ST_ERR;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            ST_ERR: begin
                state_d = out_rsp_i.ready ? ST_IDLE : ST_DRAIN;
                wait_d  = '0;
                drain_d = '0;
            end
            ST_DRAIN: begin
                if (out_rsp_i.ready || (drain_q == LAST)) begin
                    state_d = ST_IDLE;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            drain_q <= drain_d;
        end
    end

    // bus steering: pass-through, error reply, or stall; reset gates it
    always_comb begin
        out_req_o = in_req_i;
        in_rsp_o  = out_rsp_i;
        timeout_o = 1'b0;
        unique case (state_q)
            ST_ERR: begin
                out_req_o.valid = 1'b0;
                in_rsp_o.ready  = 1'b1;
                in_rsp_o.error  = 1'b1;
                in_rsp_o.rdata  = ERR_RDATA;
                timeout_o       = 1'b1;
            end
            ST_DRAIN: begin
                out_req_o.valid = 1'b0;
                in_rsp_o        = '0;
            end
            default: ;
        endcase
        if (rst_i) begin
            out_req_o.valid = 1'b0;
            in_rsp_o.ready  = 1'b0;
            timeout_o       = 1'b0;
        end
    end

    reg_timeout_sat_cnt #(
        .WIDTH(CNT_W)
    ) u_cnt (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .inc_i(err_cyc),
        .clr_i(clear_cnt_i),
        .cnt_o(timeout_cnt_o)
    );

endmodule

// File: tb/tb_reg_timeout_guard.sv
// Bench for reg_timeout_guard: directed table, random run against
// a transaction-level model, and a standalone saturation check.
module tb_reg_timeout_guard;
    import reg_timeout_guard_pkg::*;

    localparam int unsigned TO = 8;
    localparam logic [31:0] BAD = 32'hBADCAB1E;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    reg_req_t    in_req;
    reg_rsp_t    in_rsp;
    reg_req_t    out_req;
    reg_rsp_t    out_rsp;
    logic        tmo;
    logic [15:0] tcnt;

    logic        s_rst;
    logic        s_inc;
    logic        s_clr;
    logic [15:0] s_cnt;

    always #5 clk = ~clk;

    reg_timeout_guard #(
        .TIMEOUT(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .in_req_i(in_req),
        .in_rsp_o(in_rsp),
        .out_req_o(out_req),
        .out_rsp_i(out_rsp),
        .clear_cnt_i(clr),
        .timeout_o(tmo),
        .timeout_cnt_o(tcnt)
    );

    reg_timeout_sat_cnt u_sat (
        .clk_i(clk),
        .rst_i(s_rst),
        .inc_i(s_inc),
        .clr_i(s_clr),
        .cnt_o(s_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          rst;
        bit          v;
        bit          rdy;
        logic [31:0] rd;
        bit          clr;
        bit          e_ov;
        bit          e_ir;
        bit          e_err;
        logic [31:0] e_rd;
        bit          e_to;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit r, bit v, bit rdy, logic [31:0] rd,
                                bit c, bit eov, bit eir, bit eerr,
                                logic [31:0] erd, bit eto,
                                logic [15:0] ecnt);
        vec_t t;
        t.rst = r; t.v = v; t.rdy = rdy; t.rd = rd; t.clr = c;
        t.e_ov = eov; t.e_ir = eir; t.e_err = eerr; t.e_rd = erd;
        t.e_to = eto; t.e_cnt = ecnt;
        tbl.push_back(t);
    endfunction

    // transaction-level reference state
    int          age;
    bit          in_err;
    int          drain;
    int unsigned mcnt;

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        in_req = '0;
        out_rsp = '0;
        s_rst = 1'b1;
        s_inc = 1'b0;
        s_clr = 1'b0;

        // reset while a request is offered
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // peripheral ready in cycle 3
        for (int i = 0; i < 3; i++)
            add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 32'h1234, 0, 1, 1, 0, 32'h1234, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // never ready: eight forwarded cycles, then error
        for (int i = 0; i < 8; i++)
            add(0, 1, 0, 32'hDEAD, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 32'hDEAD, 0, 0, 1, 1, BAD, 1, 0);
        // new request stalls in drain, ready at drain cycle 2
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 1, 32'h4444, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 1, 32'h55, 0, 1, 1, 0, 32'h55, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // ready in last forwarded cycle 7
        for (int i = 0; i < 7; i++)
            add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        add(0, 1, 1, 32'hABCD, 0, 1, 1, 0, 32'hABCD, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // ready in cycle 8 is too late and is swallowed
        for (int i = 0; i < 8; i++)
            add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        add(0, 1, 1, 32'h7777, 0, 0, 1, 1, BAD, 1, 1);
        add(0, 1, 1, 32'h66, 0, 1, 1, 0, 32'h66, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        // clear coinciding with the error cycle
        for (int i = 0; i < 8; i++)
            add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2);
        add(0, 1, 0, 0, 1, 0, 1, 1, BAD, 1, 2);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // reset during wait at cycle 4
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 1, 32'h99, 0, 1, 1, 0, 32'h99, 0, 0);
        // drain ends after exactly TO cycles without ready
        for (int i = 0; i < 8; i++)
            add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 1, BAD, 1, 0);
        for (int i = 0; i < 8; i++)
            add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 1, 32'h11, 0, 1, 1, 0, 32'h11, 0, 1);

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            clr = tbl[i].clr;
            in_req = '0;
            in_req.addr = 32'h40;
            in_req.valid = tbl[i].v;
            out_rsp = '0;
            out_rsp.ready = tbl[i].rdy;
            out_rsp.rdata = tbl[i].rd;
            @(negedge clk);
            chk($sformatf("t%0d out_valid", i), out_req.valid, tbl[i].e_ov);
            chk($sformatf("t%0d in_ready", i), in_rsp.ready, tbl[i].e_ir);
            chk($sformatf("t%0d timeout", i), tmo, tbl[i].e_to);
            chk($sformatf("t%0d cnt", i), tcnt, tbl[i].e_cnt);
            if (tbl[i].e_ir) begin
                chk($sformatf("t%0d error", i), in_rsp.error, tbl[i].e_err);
                chk($sformatf("t%0d rdata", i), in_rsp.rdata, tbl[i].e_rd);
            end
            @(posedge clk);
            #1;
        end

        // random traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            rst = (i == 0) || ($urandom_range(199) == 0);
            clr = ($urandom_range(49) == 0);
            in_req.addr = $urandom;
            in_req.write = 1'($urandom);
            in_req.wdata = $urandom;
            in_req.wstrb = 4'($urandom);
            in_req.valid = ($urandom_range(3) != 0);
            out_rsp.rdata = $urandom;
            out_rsp.error = 1'($urandom);
            out_rsp.ready = ($urandom_range(11) == 0);
            @(negedge clk);
            if (rst) begin
                chk("r rst out_valid", out_req.valid, 1'b0);
                chk("r rst in_ready", in_rsp.ready, 1'b0);
                chk("r rst timeout", tmo, 1'b0);
            end else if (in_err) begin
                chk("r err out_valid", out_req.valid, 1'b0);
                chk("r err in_ready", in_rsp.ready, 1'b1);
                chk("r err error", in_rsp.error, 1'b1);
                chk("r err rdata", in_rsp.rdata, BAD);
                chk("r err timeout", tmo, 1'b1);
            end else if (drain >= 0) begin
                chk("r drain out_valid", out_req.valid, 1'b0);
                chk("r drain in_ready", in_rsp.ready, 1'b0);
                chk("r drain timeout", tmo, 1'b0);
            end else begin
                chk("r fwd out_req", out_req, in_req);
                chk("r fwd in_rsp", in_rsp, out_rsp);
                chk("r fwd timeout", tmo, 1'b0);
            end
            if (i > 0) chk("r cnt", tcnt, 16'(mcnt));
            if (rst) begin
                age = 0; in_err = 0; drain = -1; mcnt = 0;
            end else begin
                if (in_err) mcnt = clr ? 1 : (mcnt == 65535 ? 65535 : mcnt + 1);
                else if (clr) mcnt = 0;
                if (in_err) begin
                    in_err = 0;
                    drain = out_rsp.ready ? -1 : 0;
                end else if (drain >= 0) begin
                    if (out_rsp.ready || (drain + 1 == TO)) drain = -1;
                    else drain++;
                end else if (in_req.valid && !out_rsp.ready) begin
                    if (age + 1 == TO) begin
                        in_err = 1;
                        age = 0;
                    end else age++;
                end else age = 0;
            end
            @(posedge clk);
            #1;
        end

        // saturation of the event counter
        s_rst = 1'b0;
        @(negedge clk);
        chk("sat start", s_cnt, 16'h0);
        @(posedge clk);
        #1;
        s_inc = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat fffe", s_cnt, 16'hFFFE);
        @(posedge clk);
        #1;
        chk("sat ffff", s_cnt, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("sat hold", s_cnt, 16'hFFFF);
        s_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("sat clr+inc", s_cnt, 16'h1);
        s_inc = 1'b0;
        @(posedge clk);
        #1;
        chk("sat clr", s_cnt, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
